// File: rtl/uart_pkg.sv
// -----------------------------------------------------------------------------
// uart_pkg
// Types and helpers shared by the UART transmitter and receiver:
//   tx_state_t    - transmitter FSM state encoding
//   clks_per_bit  - system clocks per line bit (integer divide)
//   frame_bits    - total bit-times in one frame
//   calc_parity   - parity bit for a data word (even, or odd when odd=1)
// -----------------------------------------------------------------------------
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP,
        BREAK
    } tx_state_t;

    function automatic int clks_per_bit(input int sysclk, input int baud);
        return sysclk / baud;
    endfunction

    function automatic int frame_bits(input int data, input int parity, input int stop);
        return 1 + data + parity + stop;
    endfunction

    // Narrower words are zero-extended by the caller; zeros leave the XOR unchanged.
    function automatic logic calc_parity(input logic [7:0] data, input logic odd);
        return (^data) ^ odd;
    endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// -----------------------------------------------------------------------------
// uart_baud_gen
// Bit-time generator. Counts 0..CLKS_PER_BIT-1 while Enable is high and
// pulses Bit_Tick for one cycle on the terminal count.
//   Clk      in   system clock
//   Rst      in   asynchronous active-low reset
//   Enable   in   high while a frame is in flight
//   Bit_Tick out  one-cycle pulse marking the last cycle of each bit-time
// -----------------------------------------------------------------------------
module uart_baud_gen #(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic Clk,
    input  logic Rst,
    input  logic Enable,
    output logic Bit_Tick
);

    localparam int CW = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] TERM = CW'(CLKS_PER_BIT - 1);

    logic [CW-1:0] cnt_q, cnt_d;

    // The counter parks at 0 while disabled, so the first enabled cycle after
    // an accept is always count 0: every frame starts on a fresh bit boundary.
    always_comb begin
        cnt_d = cnt_q;
        if (!Enable)
            cnt_d = '0;
        else if (cnt_q == TERM)
            cnt_d = '0;
        else
            cnt_d = cnt_q + 1'b1;
    end

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst)
            cnt_q <= '0;
        else
            cnt_q <= cnt_d;
    end

    assign Bit_Tick = Enable && (cnt_q == TERM);

endmodule

// File: rtl/uart_tx.sv
// -----------------------------------------------------------------------------
// uart_tx
// Serial UART transmitter: start bit, data MSB first, optional parity,
// STOP_BITS stop bits. CTS gates only the start of a frame. A break request
// drives the line low for a full frame time followed by one mark bit.
//   Clk            in   system clock
//   Rst            in   asynchronous active-low reset
//   Tx_Data        in   word to send, sampled on the accept edge only
//   Transmit_Start in   level request to send Tx_Data
//   Break_Start    in   level request to send a break (wins over Transmit_Start)
//   CTS            in   clear-to-send, active-high
//   Tx             out  registered serial line, idle high
//   Tx_Busy        out  high while a frame is in flight
//   Tx_Done        out  one-cycle pulse when Tx_Busy falls
// -----------------------------------------------------------------------------
module uart_tx
    import uart_pkg::*;
#(
    parameter int SYSCLK_RATE = 100000000,
    parameter int BAUD_RATE   = 9600,
    parameter int DATA_BITS   = 8,
    parameter int PARITY_BIT  = 1,
    parameter int PARITY_ODD  = 0,
    parameter int STOP_BITS   = 2
) (
    input  logic                 Clk,
    input  logic                 Rst,
    input  logic [DATA_BITS-1:0] Tx_Data,
    input  logic                 Transmit_Start,
    input  logic                 Break_Start,
    input  logic                 CTS,
    output logic                 Tx,
    output logic                 Tx_Busy,
    output logic                 Tx_Done
);

    localparam int CPB        = clks_per_bit(SYSCLK_RATE, BAUD_RATE);
    localparam int FRAME_BITS = frame_bits(DATA_BITS, PARITY_BIT, STOP_BITS);
    localparam int BCW        = $clog2(FRAME_BITS + 1);

    localparam logic [BCW-1:0] LAST_DATA = BCW'(DATA_BITS - 1);
    localparam logic [BCW-1:0] LAST_STOP = BCW'(STOP_BITS - 1);
    localparam logic [BCW-1:0] LAST_BRK  = BCW'(FRAME_BITS - 1);
    localparam logic [BCW-1:0] BRK_MARK  = BCW'(FRAME_BITS);

    tx_state_t            state_q, state_d;
    logic [DATA_BITS-1:0] shreg_q, shreg_d;
    logic                 par_q, par_d;
    logic [BCW-1:0]       bit_cnt_q, bit_cnt_d;
    logic                 tx_q, tx_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;
    logic                 bit_tick;

    uart_baud_gen #(
        .CLKS_PER_BIT (CPB)
    ) u_baud (
        .Clk      (Clk),
        .Rst      (Rst),
        .Enable   (busy_q),
        .Bit_Tick (bit_tick)
    );

    // tx_d is the line value for the state being entered, so Tx comes straight
    // from a flop and changes exactly on bit boundaries.
    always_comb begin
        state_d   = state_q;
        shreg_d   = shreg_q;
        par_d     = par_q;
        bit_cnt_d = bit_cnt_q;
        tx_d      = tx_q;
        done_d    = 1'b0;

        case (state_q)
            IDLE: begin
                tx_d      = 1'b1;
                bit_cnt_d = '0;
                if (CTS && Break_Start) begin
                    // Transmit_Start is left pending and re-evaluated afterwards.
                    state_d = BREAK;
                    tx_d    = 1'b0;
                end else if (CTS && Transmit_Start) begin
                    state_d = START;
                    shreg_d = Tx_Data;
                    par_d   = calc_parity(8'(Tx_Data), PARITY_ODD != 0);
                    tx_d    = 1'b0;
                end
            end

            START: begin
                if (bit_tick) begin
                    state_d = DATA;
                    tx_d    = shreg_q[DATA_BITS-1];
                end
            end

            DATA: begin
                if (bit_tick) begin
                    if (bit_cnt_q == LAST_DATA) begin
                        bit_cnt_d = '0;
                        if (PARITY_BIT != 0) begin
                            state_d = PARITY;
                            tx_d    = par_q;
                        end else begin
                            state_d = STOP;
                            tx_d    = 1'b1;
                        end
                    end else begin
                        bit_cnt_d = bit_cnt_q + 1'b1;
                        shreg_d   = {shreg_q[DATA_BITS-2:0], 1'b0};
                        tx_d      = shreg_q[DATA_BITS-2];
                    end
                end
            end

            PARITY: begin
                if (bit_tick) begin
                    state_d = STOP;
                    tx_d    = 1'b1;
                end
            end

            STOP: begin
                if (bit_tick) begin
                    if (bit_cnt_q == LAST_STOP) begin
                        state_d   = IDLE;
                        bit_cnt_d = '0;
                        done_d    = 1'b1;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 1'b1;
                    end
                    tx_d = 1'b1;
                end
            end

            BREAK: begin
                // Counts FRAME_BITS low bit-times, then one extra count for the mark.
                if (bit_tick) begin
                    if (bit_cnt_q == BRK_MARK) begin
                        state_d   = IDLE;
                        bit_cnt_d = '0;
                        done_d    = 1'b1;
                        tx_d      = 1'b1;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 1'b1;
                        tx_d      = (bit_cnt_q == LAST_BRK);
                    end
                end
            end

            default: begin
                state_d = IDLE;
                tx_d    = 1'b1;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            state_q   <= IDLE;
            shreg_q   <= '0;
            par_q     <= 1'b0;
            bit_cnt_q <= '0;
            tx_q      <= 1'b1;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            shreg_q   <= shreg_d;
            par_q     <= par_d;
            bit_cnt_q <= bit_cnt_d;
            tx_q      <= tx_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    assign Tx      = tx_q;
    assign Tx_Busy = busy_q;
    assign Tx_Done = done_q;

endmodule

// File: tb/tb_uart_tx.sv
module tb_uart_tx;

    logic       Clk = 1'b0;
    logic       Rst = 1'b1;
    logic [7:0] Tx_Data = 8'h00;
    logic       Transmit_Start = 1'b0;
    logic       Break_Start = 1'b0;
    logic       CTS = 1'b1;
    logic [2:0] tx, busy, done;

    int total = 0;
    int bad   = 0;

    // History of the three instances, one entry per clock cycle.
    logic [2:0] txh   [0:511];
    logic [2:0] busyh [0:511];
    logic [2:0] doneh [0:511];
    int cap_n = 0;

    always #5 Clk = ~Clk;

    // 0: even parity, 1: odd parity, 2: no parity. All 16 clocks per bit, 2 stops.
    uart_tx #(.SYSCLK_RATE(16), .BAUD_RATE(1), .DATA_BITS(8), .PARITY_BIT(1),
              .PARITY_ODD(0), .STOP_BITS(2)) dut (
        .Clk(Clk), .Rst(Rst), .Tx_Data(Tx_Data), .Transmit_Start(Transmit_Start),
        .Break_Start(Break_Start), .CTS(CTS), .Tx(tx[0]), .Tx_Busy(busy[0]), .Tx_Done(done[0]));

    uart_tx #(.SYSCLK_RATE(16), .BAUD_RATE(1), .DATA_BITS(8), .PARITY_BIT(1),
              .PARITY_ODD(1), .STOP_BITS(2)) dut_odd (
        .Clk(Clk), .Rst(Rst), .Tx_Data(Tx_Data), .Transmit_Start(Transmit_Start),
        .Break_Start(Break_Start), .CTS(CTS), .Tx(tx[1]), .Tx_Busy(busy[1]), .Tx_Done(done[1]));

    uart_tx #(.SYSCLK_RATE(16), .BAUD_RATE(1), .DATA_BITS(8), .PARITY_BIT(0),
              .PARITY_ODD(0), .STOP_BITS(2)) dut_np (
        .Clk(Clk), .Rst(Rst), .Tx_Data(Tx_Data), .Transmit_Start(Transmit_Start),
        .Break_Start(Break_Start), .CTS(CTS), .Tx(tx[2]), .Tx_Busy(busy[2]), .Tx_Done(done[2]));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    task automatic do_reset();
        Transmit_Start = 1'b0;
        Break_Start    = 1'b0;
        CTS            = 1'b1;
        Rst = 1'b0;
        #2;
        Rst = 1'b1;
        step();
    endtask

    task automatic clear_hist();
        cap_n = 0;
    endtask

    // Sample the current cycle, then advance one clock.
    task automatic capture(input int n);
        for (int c = 0; c < n; c++) begin
            if (cap_n < 512) begin
                txh[cap_n]   = tx;
                busyh[cap_n] = busy;
                doneh[cap_n] = done;
                cap_n++;
            end
            step();
        end
    endtask

    task automatic start_frame();
        Transmit_Start = 1'b1;
        step();
        Transmit_Start = 1'b0;
    endtask

    // bits[nb-1] is the first bit on the line; each must hold 16 cycles with
    // Busy high and Done low, followed by the single Done cycle.
    task automatic chk_frame(input int inst, input logic [15:0] bits, input int nb,
                             input int base, input string tag);
        for (int b = 0; b < nb; b++) begin
            logic ok;
            logic e;
            int   idx;
            ok = 1'b1;
            e  = bits[nb-1-b];
            for (int c = 0; c < 16; c++) begin
                idx = base + b*16 + c;
                if (txh[idx][inst] !== e || busyh[idx][inst] !== 1'b1 || doneh[idx][inst] !== 1'b0)
                    ok = 1'b0;
            end
            chk($sformatf("%s_bit%0d", tag, b), 32'(ok), 32'd1);
        end
        chk({tag, "_busy_end"},  32'(busyh[base + nb*16][inst]), 32'd0);
        chk({tag, "_done"},      32'(doneh[base + nb*16][inst]), 32'd1);
        chk({tag, "_done_once"}, 32'(doneh[base + nb*16 + 1][inst]), 32'd0);
    endtask

    initial begin
        logic ok;

        // Reset state
        #1;
        Rst = 1'b0;
        #3;
        chk("rst_tx",   32'(tx),   32'h7);
        chk("rst_busy", 32'(busy), 32'h0);
        chk("rst_done", 32'(done), 32'h0);
        Rst = 1'b1;
        step();

        // A5 frame, data changed right after accept must not matter
        Tx_Data = 8'hA5;
        start_frame();
        Tx_Data = 8'h00;
        clear_hist();
        capture(194);
        chk_frame(0, 16'b0_10100101_0_11, 12, 0, "a5");

        // 8'h01 under even, odd and no parity
        do_reset();
        Tx_Data = 8'h01;
        start_frame();
        clear_hist();
        capture(194);
        chk_frame(0, 16'b0_00000001_1_11, 12, 0, "p_even");
        chk_frame(1, 16'b0_00000001_0_11, 12, 0, "p_odd");
        chk_frame(2, 16'b0_00000001_11,   11, 0, "p_none");

        // CTS low holds off a pending request; CTS drop mid-frame is ignored
        do_reset();
        CTS = 1'b0;
        Tx_Data = 8'hA5;
        Transmit_Start = 1'b1;
        clear_hist();
        capture(50);
        ok = 1'b1;
        for (int i = 0; i < 50; i++)
            if (txh[i][0] !== 1'b1 || busyh[i][0] !== 1'b0) ok = 1'b0;
        chk("cts_hold", 32'(ok), 32'd1);
        CTS = 1'b1;
        step();
        Transmit_Start = 1'b0;
        clear_hist();
        capture(80);
        CTS = 1'b0;
        capture(114);
        chk_frame(0, 16'b0_10100101_0_11, 12, 0, "cts");
        CTS = 1'b1;

        // Break wins over a simultaneous data request; data follows on next edge
        do_reset();
        Tx_Data = 8'h5A;
        Break_Start = 1'b1;
        Transmit_Start = 1'b1;
        step();
        Break_Start = 1'b0;
        clear_hist();
        capture(403);
        Transmit_Start = 1'b0;
        chk_frame(0, 16'b0000000000001, 13, 0, "brk");
        chk_frame(0, 16'b0_01011010_0_11, 12, 209, "after_brk");

        // Async reset in the middle of data bit 3
        do_reset();
        Tx_Data = 8'hA5;
        start_frame();
        repeat (85) step();
        chk("mid_busy", 32'(busy[0]), 32'd1);
        Rst = 1'b0;
        #2;
        chk("arst_tx",   32'(tx[0]),   32'd1);
        chk("arst_busy", 32'(busy[0]), 32'd0);
        chk("arst_done", 32'(done[0]), 32'd0);
        #1;
        Rst = 1'b1;
        step();
        step();
        chk("post_rst_idle", 32'(tx[0]), 32'd1);
        Tx_Data = 8'h3C;
        start_frame();
        clear_hist();
        capture(194);
        chk_frame(0, 16'b0_00111100_0_11, 12, 0, "x3c");

        // Back-to-back frames with Transmit_Start held
        do_reset();
        Tx_Data = 8'h00;
        Transmit_Start = 1'b1;
        step();
        Tx_Data = 8'hFF;
        clear_hist();
        capture(387);
        Transmit_Start = 1'b0;
        chk_frame(0, 16'b0_00000000_0_11, 12, 0,   "b2b_00");
        chk_frame(0, 16'b0_11111111_0_11, 12, 193, "b2b_ff");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/uart_tx.md
Name: uart_tx

Overview:
Serial UART transmitter, the far end of the UART receiver and its Rx/Rx_Error/FIFO path. It accepts one parallel word per handshake and serialises it on Tx at a programmable baud rate. Frame order is start bit, data MSB first, optional parity, STOP_BITS stop bits. It honours CTS flow control and can emit a break condition so the receiver's break-error path can be exercised in-system.

Parameters:
SYSCLK_RATE, 100000000, Clk frequency in Hz
BAUD_RATE, 9600, line bit rate in Hz; CLKS_PER_BIT = SYSCLK_RATE/BAUD_RATE (integer divide), must be >= 2
DATA_BITS, 8, data bits per frame, legal range 5..8
PARITY_BIT, 1, 1 = parity bit present, 0 = omitted
PARITY_ODD, 0, 0 = even parity (XOR of data bits), 1 = odd parity (inverted XOR)
STOP_BITS, 2, number of stop bits, legal range 1..2

Ports:
Clk  in  1  system clock
Rst  in  1  asynchronous active-low reset
Tx_Data  in  DATA_BITS  word to send; sampled only on the accept cycle
Transmit_Start  in  1  request to send Tx_Data; level-sensitive
Break_Start  in  1  request to send a break frame; level-sensitive
CTS  in  1  clear-to-send, active-high; gates the start of a new frame only
Tx  out  1  serial line, idle high
Tx_Busy  out  1  high from the accept cycle until the last stop bit completes
Tx_Done  out  1  one-cycle pulse on the cycle Tx_Busy falls

Behaviour:
- Reset (Rst low, async): Tx=1, Tx_Busy=0, Tx_Done=0, FSM=IDLE, all counters=0. Reset mid-frame aborts the frame immediately.
- FRAME_BITS = 1 + DATA_BITS + PARITY_BIT + STOP_BITS.
- FSM states: IDLE, START, DATA, PARITY, STOP, BREAK.
- Accept occurs in IDLE on a rising Clk edge with CTS=1 and (Transmit_Start=1 or Break_Start=1).
  - On accept: Tx_Data is latched into the shift register, parity is computed from the latched value, Tx_Busy=1, FSM goes to START or BREAK.
  - Tx shows the start bit (0) in the cycle after accept (1-cycle latency).
- Break_Start and Transmit_Start both high at accept: Break wins. Transmit_Start is not consumed and is re-evaluated after the break completes.
- Each bit holds for exactly CLKS_PER_BIT cycles, timed by a tick from the sub-module.
  - START lasts 1 bit, then DATA.
  - DATA sends bit DATA_BITS-1 down to bit 0 (MSB first), then PARITY if PARITY_BIT=1, else STOP.
  - PARITY lasts 1 bit, then STOP.
  - STOP sends 1 for STOP_BITS bit-times, then IDLE.
- BREAK: Tx=0 for FRAME_BITS bit-times, then Tx=1 for one bit-time (mark), then IDLE.
- End of frame: on the cycle STOP (or the break mark) completes, Tx_Busy=0 and Tx_Done=1 for one cycle. A new accept is possible on the next edge; there are no idle bits between frames.
- CTS falling mid-frame has no effect; the frame completes.
- CTS=0 with a start request pending: the block stays in IDLE with Tx=1. A request held until CTS rises is accepted on that edge.
- Tx_Data changes after accept have no effect on the frame in flight.
- Tx is registered and glitch-free.
- Bit counter width is $clog2(FRAME_BITS+1). Baud counter width is $clog2(CLKS_PER_BIT). Both wrap to 0 at terminal count.

Decomposition:
- Package uart_pkg holds:
  - tx_state_t enum (IDLE, START, DATA, PARITY, STOP, BREAK)
  - function clks_per_bit(sysclk, baud)
  - function frame_bits(data, parity, stop)
  - function calc_parity(data, odd)
  The receiver shares these.
- Sub-module uart_baud_gen: counter from 0 to CLKS_PER_BIT-1.
  - It restarts to 0 on an Enable rising (accept) and emits a one-cycle Bit_Tick at terminal count.
  - Inputs: Clk, Rst, Enable. Output: Bit_Tick.

Test Plan:
- SYSCLK_RATE=16, BAUD_RATE=1, DATA_BITS=8, PARITY_BIT=1, even parity, STOP_BITS=2; Tx_Data=8'hA5 with Transmit_Start for 1 cycle, CTS=1 -> Tx sequence 0,1,0,1,0,0,1,0,1,0,1,1, each held 16 cycles. Tx_Busy high for 192 cycles, Tx_Done pulses once.
- Tx_Data=8'h01 with PARITY_ODD=0 -> parity bit 1. Same word with PARITY_ODD=1 -> parity bit 0. With PARITY_BIT=0 -> frame is 11 bits and the parity slot is absent.
- CTS=0 with Transmit_Start held high for 50 cycles, then CTS=1 -> Tx stays 1 and Tx_Busy stays 0 for those 50 cycles, then the start bit appears 1 cycle after CTS rises. Dropping CTS mid-frame -> frame completes unchanged.
- Break_Start and Transmit_Start asserted together -> Tx low for 12x16=192 cycles, then high for 16 cycles, then Tx_Done. The pending data frame starts on the next edge.
- Rst pulsed low during DATA bit 3 -> Tx=1 and Tx_Busy=0 asynchronously. After Rst rises, a new 8'h3C frame is sent correctly from the start bit.
- Back-to-back: Transmit_Start held high with Tx_Data 8'h00 then 8'hFF -> the second start bit follows the first frame's final stop bit with zero idle cycles. Loopback into the receiver yields Data_Out 8'h00 then 8'hFF with Rx_Error=3'b000.
